// File: rtl/hit_judge.sv
// hit_judge: debounces five drum pads and judges strikes against the falling cube row.
// Reports hits/misses/wrong strikes, keeps score and combo. Optional macro: HIT_PERFECTO_EN.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            row restart (row state only; score/combo/debouncers kept)
//   posicionYS        current Y of the cube row, wraps to 0 at each new row
//   cubosHileraReg    lanes populated in the current row (bit0 = lane 1)
//   pads              raw active-high pads, asynchronous to clk
//   golpe             per-lane pulse on a correct hit
//   fallo             pulse when populated lanes were left unstruck at window close
//   error             pulse on a strike with no pending cube or outside the window
//   consumidos        lanes already hit in the current row
//   puntaje, combo    saturating score and consecutive-hit count
//   perfecto          (HIT_PERFECTO_EN only) pulse alongside golpe for a centred hit

module hit_judge #(
  parameter int unsigned ZONA_INI   = 400,
  parameter int unsigned ZONA_FIN   = 440,
  parameter int unsigned DEB_CICLOS = 50000,
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned PUNTOS_HIT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  posicionYS,
  input  logic [4:0]  cubosHileraReg,
  input  logic [4:0]  pads,
  output logic [4:0]  golpe,
  output logic        fallo,
  output logic        error,
  output logic [4:0]  consumidos,
  output logic [15:0] puntaje,
  output logic [7:0]  combo
`ifdef HIT_PERFECTO_EN
  ,
  output logic        perfecto
`endif
);

  typedef enum logic [1:0] {
    ESPERA,
    VENTANA,
    CIERRE,
    HECHO
  } estado_t;

  localparam logic [9:0] ZI = ZONA_INI[9:0];
  localparam logic [9:0] ZF = ZONA_FIN[9:0];
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CICLOS - 1);
  localparam logic [19:0] PTS = 20'(PUNTOS_HIT);

`ifdef HIT_PERFECTO_EN
  localparam int unsigned CENTRO = (ZONA_INI + ZONA_FIN) / 2;
  localparam logic [9:0] CMIN = 10'(CENTRO - 4);
  localparam logic [9:0] CMAX = 10'(CENTRO + 4);
`endif

  // pad synchronizer and debouncer state
  logic [4:0]       sync1_q, sync2_q;
  logic [4:0]       lvl_q, lvl_d;
  logic [4:0]       lvl_prev_q;
  logic [DEB_W-1:0] cnt_q [5];
  logic [DEB_W-1:0] cnt_d [5];
  logic [4:0]       strike;

  // row / judge state
  estado_t     state_q, state_d;
  logic [9:0]  prev_y_q;
  logic [4:0]  pend_q, pend_d;
  logic [4:0]  cons_q, cons_d;
  logic [4:0]  golpe_q, golpe_d;
  logic        fallo_q, fallo_d;
  logic        error_q, error_d;
  logic [15:0] punt_q, punt_d;
  logic [7:0]  combo_q, combo_d;
`ifdef HIT_PERFECTO_EN
  logic        perf_q, perf_d;
  logic        en_centro;
`endif

  // combinational helpers
  logic        en_zona;
  logic        pasado;
  logic        new_row;
  logic [4:0]  hit;
  logic [4:0]  wrong;
  logic [2:0]  n_ok;
  logic [19:0] add_pts;
  logic [19:0] sum_pts;
  logic [8:0]  combo_sum;

  // ---------------- debounce ----------------
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // one-cycle event on each accepted press
  assign strike = lvl_q & ~lvl_prev_q;

  // ---------------- judge ----------------
  assign en_zona = (posicionYS >= ZI) && (posicionYS <= ZF);
  assign pasado  = posicionYS > ZF;
  assign new_row = (posicionYS < prev_y_q) || enable;

`ifdef HIT_PERFECTO_EN
  assign en_centro = (posicionYS >= CMIN) && (posicionYS <= CMAX);
`endif

  always_comb begin
    hit   = (state_q == VENTANA) ? (strike & pend_q) : 5'b0;
    wrong = strike & ~hit;

    n_ok    = '0;
    add_pts = '0;
    for (int i = 0; i < 5; i++) begin
      if (hit[i]) begin
        n_ok = n_ok + 3'd1;
`ifdef HIT_PERFECTO_EN
        add_pts = add_pts + (en_centro ? (PTS << 1) : PTS);
`else
        add_pts = add_pts + PTS;
`endif
      end
    end

    sum_pts   = {4'b0, punt_q} + add_pts;
    combo_sum = {1'b0, combo_q} + {6'b0, n_ok};

    state_d = state_q;
    pend_d  = pend_q & ~hit;
    cons_d  = cons_q | hit;
    golpe_d = hit;
    error_d = |wrong;
    fallo_d = 1'b0;
    punt_d  = (|sum_pts[19:16]) ? 16'hFFFF : sum_pts[15:0];
`ifdef HIT_PERFECTO_EN
    perf_d  = (|hit) && en_centro;
`endif

    unique case (state_q)
      ESPERA: begin
        if (en_zona) state_d = VENTANA;
      end
      VENTANA: begin
        // a hit on this same cycle already cleared its pending bit
        if (pasado) state_d = CIERRE;
      end
      CIERRE: begin
        state_d = HECHO;
        if (pend_q != 5'b0) begin
          fallo_d = 1'b1;
          pend_d  = 5'b0;
        end
      end
      HECHO: begin
        state_d = HECHO;
      end
      default: state_d = ESPERA;
    endcase

    // a new row overrides close-out of the old one
    if (new_row) begin
      pend_d  = cubosHileraReg;
      cons_d  = 5'b0;
      state_d = ESPERA;
      fallo_d = 1'b0;
    end

    // any wrong lane or miss kills the combo, even if other lanes hit
    if ((|wrong) || fallo_d) begin
      combo_d = 8'd0;
    end else begin
      combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      state_q    <= ESPERA;
      prev_y_q   <= '0;
      pend_q     <= '0;
      cons_q     <= '0;
      golpe_q    <= '0;
      fallo_q    <= 1'b0;
      error_q    <= 1'b0;
      punt_q     <= '0;
      combo_q    <= '0;
`ifdef HIT_PERFECTO_EN
      perf_q     <= 1'b0;
`endif
    end else begin
      sync1_q    <= pads;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      prev_y_q   <= posicionYS;
      pend_q     <= pend_d;
      cons_q     <= cons_d;
      golpe_q    <= golpe_d;
      fallo_q    <= fallo_d;
      error_q    <= error_d;
      punt_q     <= punt_d;
      combo_q    <= combo_d;
`ifdef HIT_PERFECTO_EN
      perf_q     <= perf_d;
`endif
    end
  end

  assign golpe      = golpe_q;
  assign fallo      = fallo_q;
  assign error      = error_q;
  assign consumidos = cons_q;
  assign puntaje    = punt_q;
  assign combo      = combo_q;
`ifdef HIT_PERFECTO_EN
  assign perfecto   = perf_q;
`endif

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed scoreboard bench for hit_judge (DEB_CICLOS=4).
// Stimulus pushes expected events; a negedge monitor pops and compares.

module tb_hit_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  posicionYS;
  logic [4:0]  cubos;
  logic [4:0]  pads;
  logic [4:0]  golpe;
  logic        fallo;
  logic        error;
  logic [4:0]  consumidos;
  logic [15:0] puntaje;
  logic [7:0]  combo;
  logic        perf_w;

`ifdef HIT_PERFECTO_EN
  localparam int  PP = 20;
  localparam bit  PE = 1'b1;
`else
  localparam int  PP = 10;
  localparam bit  PE = 1'b0;
  assign perf_w = 1'b0;
`endif

  hit_judge #(
    .DEB_CICLOS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .posicionYS(posicionYS),
    .cubosHileraReg(cubos),
    .pads(pads),
    .golpe(golpe),
    .fallo(fallo),
    .error(error),
    .consumidos(consumidos),
    .puntaje(puntaje),
    .combo(combo)
`ifdef HIT_PERFECTO_EN
    ,
    .perfecto(perf_w)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  golpe;
    logic        fallo;
    logic        error;
    logic [4:0]  cons;
    logic [15:0] punt;
    logic [7:0]  combo;
    logic        perf;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic void push(logic [4:0] g, logic f, logic e,
                               logic [4:0] c, int p, int cb, logic pf);
    ev_t ev;
    ev.golpe = g;
    ev.fallo = f;
    ev.error = e;
    ev.cons  = c;
    ev.punt  = 16'(p);
    ev.combo = 8'(cb);
    ev.perf  = pf;
    exp_q.push_back(ev);
  endfunction

  // monitor: every output pulse must match the next expected event
  always @(negedge clk) begin
    ev_t act;
    ev_t ex;
    if (!reset && (golpe != 5'b0 || fallo || error)) begin
      act = {golpe, fallo, error, consumidos, puntaje, combo, perf_w};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got g=%b f=%b e=%b c=%b p=%0d cb=%0d pf=%b need none",
                 act.golpe, act.fallo, act.error, act.cons, act.punt, act.combo, act.perf);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          bad++;
          $display("FAIL event got g=%b f=%b e=%b c=%b p=%0d cb=%0d pf=%b need g=%b f=%b e=%b c=%b p=%0d cb=%0d pf=%b",
                   act.golpe, act.fallo, act.error, act.cons, act.punt, act.combo, act.perf,
                   ex.golpe, ex.fallo, ex.error, ex.cons, ex.punt, ex.combo, ex.perf);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(int a, int b);
    for (int y = a; y <= b; y++) begin
      posicionYS = 10'(y);
      cyc();
    end
  endtask

  task automatic strike(logic [4:0] m);
    pads = m;
    repeat (10) cyc();
    pads = 5'b0;
    repeat (12) cyc();
  endtask

  task automatic start_row(logic [4:0] m);
    cubos      = m;
    posicionYS = 10'd0;
    enable     = 1'b1;
    cyc();
    enable     = 1'b0;
  endtask

  task automatic check_zero(string name);
    logic [39:0] v;
    v = {golpe, fallo, error, consumidos, puntaje, combo, perf_w};
    total++;
    if (v !== 40'b0) begin
      bad++;
      $display("FAIL %s got g=%b f=%b e=%b c=%b p=%0d cb=%0d need all zero",
               name, golpe, fallo, error, consumidos, puntaje, combo);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    posicionYS = 10'd0;
    cubos      = 5'b0;
    pads       = 5'b0;
    repeat (3) cyc();
    check_zero("reset_state");
    reset = 1'b0;

    // row 1: two separate hits, no miss
    start_row(5'b00101);
    sweep(1, 410);
    push(5'b00001, 0, 0, 5'b00001, 10, 1, 0);
    strike(5'b00001);
    sweep(411, 430);
    push(5'b00100, 0, 0, 5'b00101, 20, 2, 0);
    strike(5'b00100);
    sweep(431, 480);

    // row 2: one lane left unstruck -> fallo
    start_row(5'b00011);
    sweep(1, 415);
    push(5'b00001, 0, 0, 5'b00001, 30, 3, 0);
    strike(5'b00001);
    push(5'b00000, 1, 0, 5'b00001, 30, 0, 0);
    sweep(416, 480);

    // row 3: strike outside window, then the whole row missed
    start_row(5'b11111);
    sweep(1, 200);
    push(5'b00000, 0, 1, 5'b00000, 30, 0, 0);
    strike(5'b01000);
    push(5'b00000, 1, 0, 5'b00000, 30, 0, 0);
    sweep(201, 480);

    // row 4: short glitch ignored, held press gives exactly one hit
    start_row(5'b00001);
    sweep(1, 405);
    pads = 5'b00001;
    repeat (2) cyc();
    pads = 5'b00000;
    repeat (12) cyc();
    sweep(406, 410);
    push(5'b00001, 0, 0, 5'b00001, 40, 1, 0);
    strike(5'b00001);
    sweep(411, 480);

    // row 5: two lanes struck together at the window centre
    start_row(5'b00011);
    sweep(1, 420);
    push(5'b00011, 0, 0, 5'b00011, 40 + 2 * PP, 3, PE);
    strike(5'b00011);
    sweep(421, 480);

    // row 6: reset mid-window clears everything, no fallo afterwards
    start_row(5'b00111);
    sweep(1, 410);
    push(5'b00001, 0, 0, 5'b00001, 50 + 2 * PP, 4, 0);
    strike(5'b00001);
    sweep(411, 415);
    push(5'b00010, 0, 0, 5'b00011, 60 + 2 * PP, 5, 0);
    strike(5'b00010);
    sweep(416, 420);
    reset = 1'b1;
    cyc();
    check_zero("mid_reset");
    reset = 1'b0;
    sweep(421, 480);

    // row 7: right and wrong lane in one cycle -> hit scores, combo 0
    start_row(5'b00001);
    sweep(1, 420);
    push(5'b00001, 0, 1, 5'b00001, PP, 0, PE);
    strike(5'b00011);
    sweep(421, 480);

    repeat (5) cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got %0d pending need 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
